// File: rtl/noc_link_monitor.sv
// noc_link_monitor
//   Passive observer for one NoC link direction. It rebuilds packet boundaries
//   for each virtual channel and checks the valid/ready stall rule. For every
//   completed packet it queues one record through a show-ahead FIFO that has a
//   valid/ready output handshake.
//
// Ports
//   clk, rst          : sole clock; synchronous active-high reset
//   flit_i            : 32-bit link flit shared by all channels
//   last_i/valid_i/ready_i [CHANNELS] : per-channel tail, valid, ready taps
//   rec_valid_o/rec_ready_i : record FIFO handshake (pop when both high)
//   rec_channel_o/rec_dest_o/rec_len_o/rec_cycles_o : head record fields
//   pkt_count_o       : completed packets (wraps)
//   drop_count_o      : records lost to a full FIFO (saturates)
//   err_stall_o       : sticky stall-rule violation per channel
//   err_multi_o       : sticky, more than one channel transferred in a cycle
module noc_link_monitor #(
    parameter int  CHANNELS   = 1,
    parameter int  DEST_WIDTH = 5,
    parameter int  LEN_WIDTH  = 8,
    parameter int  CYC_WIDTH  = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           flit_i,
    input  logic [CHANNELS-1:0]   last_i,
    input  logic [CHANNELS-1:0]   valid_i,
    input  logic [CHANNELS-1:0]   ready_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [CH_W-1:0]       rec_channel_o,
    output logic [DEST_WIDTH-1:0] rec_dest_o,
    output logic [LEN_WIDTH-1:0]  rec_len_o,
    output logic [CYC_WIDTH-1:0]  rec_cycles_o,
    output logic [31:0]           pkt_count_o,
    output logic [15:0]           drop_count_o,
    output logic [CHANNELS-1:0]   err_stall_o,
    output logic                  err_multi_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = CH_W + DEST_WIDTH + LEN_WIDTH + CYC_WIDTH;

    typedef enum logic {S_IDLE = 1'b0, S_BODY = 1'b1} state_t;

    function automatic logic [LEN_WIDTH-1:0] sat_inc_len(input logic [LEN_WIDTH-1:0] v);
        return (&v) ? v : v + LEN_WIDTH'(1);
    endfunction

    function automatic logic [CYC_WIDTH-1:0] sat_inc_cyc(input logic [CYC_WIDTH-1:0] v);
        return (&v) ? v : v + CYC_WIDTH'(1);
    endfunction

    state_t                r_state    [CHANNELS];
    state_t                w_state_nxt[CHANNELS];
    logic [DEST_WIDTH-1:0] r_dest     [CHANNELS];
    logic [DEST_WIDTH-1:0] w_dest_nxt [CHANNELS];
    logic [LEN_WIDTH-1:0]  r_len      [CHANNELS];
    logic [LEN_WIDTH-1:0]  w_len_nxt  [CHANNELS];
    logic [CYC_WIDTH-1:0]  r_cyc      [CHANNELS];
    logic [CYC_WIDTH-1:0]  w_cyc_nxt  [CHANNELS];
    logic [31:0]           r_hold     [CHANNELS];

    logic [CHANNELS-1:0]   r_pend;
    logic [CHANNELS-1:0]   r_err_stall;
    logic                  r_err_multi;
    logic [31:0]           r_pkt_count;
    logic [15:0]           r_drop_count;

    logic [CHANNELS-1:0]   w_xfer;
    logic [CHANNELS-1:0]   w_take;
    logic                  w_multi;
    logic [CHANNELS-1:0]   w_stall_viol;

    logic                  w_done;
    logic [CH_W-1:0]       w_rec_ch;
    logic [DEST_WIDTH-1:0] w_rec_dest;
    logic [LEN_WIDTH-1:0]  w_rec_len;
    logic [CYC_WIDTH-1:0]  w_rec_cyc;

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [REC_W-1:0]      r_mem [FIFO_DEPTH];
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [REC_W-1:0]      w_head;

    // Only the lowest-index transferring channel is processed; x & -x isolates it.
    assign w_xfer  = valid_i & ready_i;
    assign w_take  = w_xfer & (~w_xfer + CHANNELS'(1));
    assign w_multi = |(w_xfer & (w_xfer - CHANNELS'(1)));

    // Per-channel packet FSM next state; at most one channel completes per cycle.
    always_comb begin
        w_done     = 1'b0;
        w_rec_ch   = '0;
        w_rec_dest = '0;
        w_rec_len  = '0;
        w_rec_cyc  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_state_nxt[c] = r_state[c];
            w_dest_nxt[c]  = r_dest[c];
            w_len_nxt[c]   = r_len[c];
            w_cyc_nxt[c]   = r_cyc[c];
            case (r_state[c])
                S_IDLE: begin
                    if (w_take[c]) begin
                        if (last_i[c]) begin
                            w_done     = 1'b1;
                            w_rec_ch   = CH_W'(c);
                            w_rec_dest = flit_i[31 -: DEST_WIDTH];
                            w_rec_len  = LEN_WIDTH'(1);
                            w_rec_cyc  = CYC_WIDTH'(1);
                        end else begin
                            w_state_nxt[c] = S_BODY;
                            w_dest_nxt[c]  = flit_i[31 -: DEST_WIDTH];
                            w_len_nxt[c]   = LEN_WIDTH'(1);
                            w_cyc_nxt[c]   = CYC_WIDTH'(1);
                        end
                    end
                end
                S_BODY: begin
                    // Duration counts every cycle in the packet, stalls included.
                    w_cyc_nxt[c] = sat_inc_cyc(r_cyc[c]);
                    if (w_take[c]) begin
                        w_len_nxt[c] = sat_inc_len(r_len[c]);
                        if (last_i[c]) begin
                            w_state_nxt[c] = S_IDLE;
                            w_done         = 1'b1;
                            w_rec_ch       = CH_W'(c);
                            w_rec_dest     = r_dest[c];
                            w_rec_len      = sat_inc_len(r_len[c]);
                            w_rec_cyc      = sat_inc_cyc(r_cyc[c]);
                        end
                    end
                end
                default: w_state_nxt[c] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) r_state[c] <= S_IDLE;
            else     r_state[c] <= w_state_nxt[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            r_dest[c] <= w_dest_nxt[c];
            r_len[c]  <= w_len_nxt[c];
            r_cyc[c]  <= w_cyc_nxt[c];
            r_hold[c] <= flit_i;
        end
    end

    // A stalled beat must be presented again unchanged on the next cycle.
    always_comb begin
        w_stall_viol = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_stall_viol[c] = r_pend[c] & (~valid_i[c] | (flit_i != r_hold[c]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_err_stall <= '0;
            r_err_multi <= 1'b0;
        end else begin
            r_pend      <= valid_i & ~ready_i;
            r_err_stall <= r_err_stall | w_stall_viol;
            if (w_multi) r_err_multi <= 1'b1;
        end
    end

    // Record FIFO: extra pointer bit separates full from empty. A push into a
    // full FIFO still lands when the head is popped in the same cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & rec_ready_i;
    assign w_push  = w_done & (~w_full | w_pop);
    assign w_drop  = w_done & ~w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_rec_ch, w_rec_dest, w_rec_len, w_rec_cyc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_done) r_pkt_count <= r_pkt_count + 32'd1;
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign {rec_channel_o, rec_dest_o, rec_len_o, rec_cycles_o} = w_head;
    assign rec_valid_o  = ~w_empty;
    assign pkt_count_o  = r_pkt_count;
    assign drop_count_o = r_drop_count;
    assign err_stall_o  = r_err_stall;
    assign err_multi_o  = r_err_multi;

endmodule

// File: tb/tb_noc_link_monitor.sv
// Testbench for noc_link_monitor (CHANNELS=2, FIFO_DEPTH=4). A packet-level
// model predicts the record queue, counters and error flags. Literal checks
// after each directed scenario pin the model.
module tb_noc_link_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] flit_i;
    logic [1:0]  last_i, valid_i, ready_i;
    logic        rec_ready_i;
    logic        rec_valid_o;
    logic        rec_channel_o;
    logic [4:0]  rec_dest_o;
    logic [7:0]  rec_len_o;
    logic [15:0] rec_cycles_o;
    logic [31:0] pkt_count_o;
    logic [15:0] drop_count_o;
    logic [1:0]  err_stall_o;
    logic        err_multi_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_link_monitor #(
        .CHANNELS(2), .DEST_WIDTH(5), .LEN_WIDTH(8), .CYC_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .flit_i(flit_i), .last_i(last_i),
        .valid_i(valid_i), .ready_i(ready_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_channel_o(rec_channel_o), .rec_dest_o(rec_dest_o),
        .rec_len_o(rec_len_o), .rec_cycles_o(rec_cycles_o),
        .pkt_count_o(pkt_count_o), .drop_count_o(drop_count_o),
        .err_stall_o(err_stall_o), .err_multi_o(err_multi_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- packet-level model ----------------
    typedef struct { int ch; int dest; int len; int cyc; } rec_t;
    rec_t        mq[$];
    bit          m_in[2];
    int          m_n[2];
    int          m_start[2];
    int          m_dest[2];
    bit          m_pend[2];
    logic [31:0] m_hold[2];
    bit   [1:0]  m_err_stall;
    bit          m_err_multi;
    int          m_pkt;
    int          m_drop;
    int          m_cycle = 0;
    bit          started = 0;

    always @(posedge clk) begin : model
        int c;
        bit pop;
        logic [1:0] xfer;
        rec_t r;
        started = 1;
        m_cycle++;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < 2; k++) begin
                m_in[k] = 0; m_pend[k] = 0;
            end
            m_err_stall = 0; m_err_multi = 0; m_pkt = 0; m_drop = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (m_pend[k] && (!valid_i[k] || flit_i !== m_hold[k])) m_err_stall[k] = 1;
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = valid_i[k] && !ready_i[k];
                m_hold[k] = flit_i;
            end
            xfer = valid_i & ready_i;
            if (xfer == 2'b11) m_err_multi = 1;
            c = xfer[0] ? 0 : (xfer[1] ? 1 : -1);
            pop = (mq.size() > 0) && rec_ready_i;
            if (pop) void'(mq.pop_front());
            if (c >= 0) begin
                if (!m_in[c]) begin
                    m_in[c] = 1; m_start[c] = m_cycle; m_n[c] = 0;
                    m_dest[c] = int'(flit_i[31:27]);
                end
                m_n[c]++;
                if (last_i[c]) begin
                    m_in[c] = 0;
                    r.ch   = c;
                    r.dest = m_dest[c];
                    r.len  = (m_n[c] > 255) ? 255 : m_n[c];
                    r.cyc  = (m_cycle - m_start[c] + 1 > 65535) ? 65535 : m_cycle - m_start[c] + 1;
                    m_pkt++;
                    if (mq.size() < 4) mq.push_back(r);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("rec_valid", 64'(rec_valid_o), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("rec_channel", 64'(rec_channel_o), 64'(mq[0].ch));
                check("rec_dest",    64'(rec_dest_o),    64'(mq[0].dest));
                check("rec_len",     64'(rec_len_o),     64'(mq[0].len));
                check("rec_cycles",  64'(rec_cycles_o),  64'(mq[0].cyc));
            end
            check("pkt_count",  64'(pkt_count_o),  64'(m_pkt));
            check("drop_count", 64'(drop_count_o), 64'(m_drop));
            check("err_stall",  64'(err_stall_o),  64'(m_err_stall));
            check("err_multi",  64'(err_multi_o),  64'(m_err_multi));
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] r, input logic [1:0] l,
                        input logic [31:0] f, input logic rr);
        valid_i = v; ready_i = r; last_i = l; flit_i = f; rec_ready_i = rr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        step(2'b00, 2'b00, 2'b00, 32'h0, rr);
    endtask

    function automatic logic [31:0] hdr(input int d);
        logic [4:0] d5;
        d5 = 5'(d);
        return {d5, 27'h0};
    endfunction

    initial begin
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        check("reset_rec_valid", 64'(rec_valid_o), 64'd0);
        check("reset_pkt",       64'(pkt_count_o), 64'd0);
        check("reset_drop",      64'(drop_count_o), 64'd0);
        check("reset_err_stall", 64'(err_stall_o), 64'd0);
        check("reset_err_multi", 64'(err_multi_o), 64'd0);

        // single-flit packet on ch0
        step(2'b01, 2'b01, 2'b01, 32'h2800_0000, 1'b1);
        check("s1_valid", 64'(rec_valid_o), 64'd1);
        check("s1_ch",    64'(rec_channel_o), 64'd0);
        check("s1_dest",  64'(rec_dest_o), 64'd5);
        check("s1_len",   64'(rec_len_o), 64'd1);
        check("s1_cyc",   64'(rec_cycles_o), 64'd1);
        check("s1_pkt",   64'(pkt_count_o), 64'd1);
        idle(1'b1);

        // 4-flit packet on ch1 with a two-cycle legal stall
        step(2'b10, 2'b10, 2'b00, 32'hF800_0000, 1'b1);
        step(2'b10, 2'b10, 2'b00, 32'hA1A1_A1A1, 1'b1);
        step(2'b10, 2'b00, 2'b00, 32'hA2A2_A2A2, 1'b1);
        step(2'b10, 2'b00, 2'b00, 32'hA2A2_A2A2, 1'b1);
        step(2'b10, 2'b10, 2'b00, 32'hA2A2_A2A2, 1'b1);
        step(2'b10, 2'b10, 2'b10, 32'hA3A3_A3A3, 1'b1);
        check("s2_ch",    64'(rec_channel_o), 64'd1);
        check("s2_dest",  64'(rec_dest_o), 64'd31);
        check("s2_len",   64'(rec_len_o), 64'd4);
        check("s2_cyc",   64'(rec_cycles_o), 64'd6);
        check("s2_stall", 64'(err_stall_o), 64'd0);
        idle(1'b1);

        // stall violation on ch0: flit changes while stalled
        step(2'b01, 2'b00, 2'b00, 32'h1111_1111, 1'b1);
        step(2'b01, 2'b00, 2'b00, 32'h2222_2222, 1'b1);
        check("s3_stall_set", 64'(err_stall_o), 64'd1);
        step(2'b01, 2'b01, 2'b01, 32'h2222_2222, 1'b1);
        idle(1'b1);
        check("s3_stall_sticky", 64'(err_stall_o), 64'd1);

        // FIFO overflow and push-while-full-with-pop
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) step(2'b01, 2'b01, 2'b01, hdr(i), 1'b0);
        check("s4_drop",  64'(drop_count_o), 64'd2);
        check("s4_pkt",   64'(pkt_count_o), 64'd6);
        check("s4_head",  64'(rec_dest_o), 64'd1);
        step(2'b01, 2'b01, 2'b01, hdr(7), 1'b1);
        check("s4_drop_kept", 64'(drop_count_o), 64'd2);
        check("s4_head2", 64'(rec_dest_o), 64'd2);
        idle(1'b1);
        check("s4_head3", 64'(rec_dest_o), 64'd3);
        idle(1'b1);
        check("s4_head4", 64'(rec_dest_o), 64'd4);
        idle(1'b1);
        check("s4_head7", 64'(rec_dest_o), 64'd7);
        idle(1'b1);
        check("s4_empty", 64'(rec_valid_o), 64'd0);

        // simultaneous handshakes on both channels
        step(2'b11, 2'b11, 2'b11, hdr(9), 1'b1);
        check("s5_multi", 64'(err_multi_o), 64'd1);
        check("s5_ch",    64'(rec_channel_o), 64'd0);
        check("s5_dest",  64'(rec_dest_o), 64'd9);
        check("s5_pkt",   64'(pkt_count_o), 64'd8);
        idle(1'b1);

        // long packet on ch1: length saturates, duration does not
        for (int i = 0; i < 300; i++)
            step(2'b10, 2'b10, (i == 299) ? 2'b10 : 2'b00, (i == 0) ? hdr(17) : 32'(i), 1'b1);
        check("s6_len_sat", 64'(rec_len_o), 64'd255);
        check("s6_cyc",     64'(rec_cycles_o), 64'd300);
        check("s6_dest",    64'(rec_dest_o), 64'd17);
        idle(1'b1);

        // reset in the middle of a packet
        step(2'b01, 2'b01, 2'b00, hdr(3), 1'b1);
        step(2'b01, 2'b01, 2'b00, 32'h0000_0033, 1'b1);
        step(2'b01, 2'b01, 2'b00, 32'h0000_0034, 1'b1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        check("s7_pkt_zero",   64'(pkt_count_o), 64'd0);
        check("s7_multi_zero", 64'(err_multi_o), 64'd0);
        step(2'b01, 2'b01, 2'b00, hdr(12), 1'b1);
        step(2'b01, 2'b01, 2'b01, 32'h0000_0077, 1'b1);
        check("s7_len",  64'(rec_len_o), 64'd2);
        check("s7_cyc",  64'(rec_cycles_o), 64'd2);
        check("s7_dest", 64'(rec_dest_o), 64'd12);
        check("s7_pkt",  64'(pkt_count_o), 64'd1);
        idle(1'b1);
        check("s7_empty", 64'(rec_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
